// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and pick helpers for the weighted round-robin arbiter
package arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   // widest requester vector the helpers below can scan
   localparam int MAX_N = 64;
   function automatic int iw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic [MAX_N-1:0] onehot(input int idx);
      return MAX_N'(1) << idx;
   endfunction
   // lowest set bit above ptr, else lowest set bit overall (wrap), else 0
   function automatic int ffs_from(input logic [MAX_N-1:0] vec, input int ptr);
      int first;
      int masked;
      first = 0;
      masked = -1;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (vec[i]) first = i;
         if (vec[i] && i > ptr) masked = i;
      end
      return (masked >= 0) ? masked : first;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select starting just after ptr
module rr_pick import arb_pkg::*; #(
   parameter int N  = 32,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   // masked find-first-set with fallback to the full vector when nothing lies above ptr
   always_comb begin
      any = |vec;
      idx = IW'(ffs_from(MAX_N'(vec), int'(ptr)));
      onehot = any ? N'(arb_pkg::onehot(int'(idx))) : '0;
   end
endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter holding a grant for up to weight+1 acked beats
module wrr_arbiter import arb_pkg::*; #(
   parameter int N  = 32,
   parameter int WW = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*WW-1:0]       weight,
   input  logic                  ack,
   output logic [N-1:0]          gnt,
   output logic [iw(N)-1:0]      gnt_id,
   output logic                  gnt_valid
);
   localparam int IW = iw(N);
   arb_state_t    state;
   logic [IW-1:0] ptr, cur, pidx, pptr;
   logic [WW-1:0] credit;
   logic [N-1:0]  pvec, poh;
   logic          pany, rel;
   // candidates: all requesters when idle, everyone but the holder when releasing
   always_comb begin
      pvec = (state == GRANT) ? (req & ~gnt) : req;
      pptr = (state == GRANT) ? cur : ptr;
      rel = (state == GRANT) && (!req[cur] || (ack && credit == '0));
   end
   rr_pick #(.N(N), .IW(IW)) u_pick (
      .vec(pvec),
      .ptr(pptr),
      .onehot(poh),
      .idx(pidx),
      .any(pany)
   );
   assign gnt_valid = |gnt;
   // grant FSM: load winner, count down burst credit, hand over or regrant on release
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= IW'(N - 1);
         cur <= '0;
         credit <= '0;
         gnt <= '0;
         gnt_id <= '0;
      end else if (state == IDLE) begin
         if (pany) begin
            state <= GRANT;
            cur <= pidx;
            gnt <= poh;
            gnt_id <= pidx;
            credit <= weight[pidx*WW +: WW];
         end
      end else if (rel) begin
         ptr <= cur;
         if (pany) begin
            cur <= pidx;
            gnt <= poh;
            gnt_id <= pidx;
            credit <= weight[pidx*WW +: WW];
         end else if (req[cur]) begin
            credit <= weight[cur*WW +: WW];
         end else begin
            state <= IDLE;
            gnt <= '0;
            gnt_id <= '0;
            credit <= '0;
         end
      end else if (ack) begin
         credit <= credit - 1'b1;
      end
   end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed and randomized checks of wrr_arbiter against a behavioural model
module tb_wrr_arbiter;
   localparam int N = 4;
   localparam int WW = 2;
   localparam int BOUND = (N - 1) * (1 << WW);
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ack = 1'b0;
   logic [N-1:0] req = '0;
   logic [N*WW-1:0] weight = '0;
   logic [N-1:0] gnt;
   logic [1:0] gnt_id;
   logic gnt_valid;
   int total = 0;
   int bad = 0;
   int m_cur = -1;
   int m_last = N - 1;
   int m_left = 0;
   int wait_cnt[N];
   bit rnd_on = 0;
   int seq1[5] = '{1, 2, 4, 8, 1};
   int seq2[5] = '{1, 2, 2, 2, 1};

   always #5 clk = ~clk;

   wrr_arbiter #(.N(N), .WW(WW)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .weight(weight),
      .ack(ack),
      .gnt(gnt),
      .gnt_id(gnt_id),
      .gnt_valid(gnt_valid)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] rq, input int last, input int excl);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (rq[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic int wgt(input int i);
      return int'(weight[i*WW +: WW]);
   endfunction

   task automatic model_step();
      int nxt;
      if (rst) begin
         m_cur = -1;
         m_last = N - 1;
         m_left = 0;
      end else if (m_cur < 0) begin
         m_cur = pick(req, m_last, -1);
         if (m_cur >= 0) m_left = wgt(m_cur) + 1;
      end else if (!req[m_cur] || (ack && m_left == 1)) begin
         m_last = m_cur;
         nxt = pick(req, m_last, m_cur);
         if (nxt >= 0) begin
            m_cur = nxt;
            m_left = wgt(nxt) + 1;
         end else if (req[m_cur]) begin
            m_left = wgt(m_cur) + 1;
         end else begin
            m_cur = -1;
         end
      end else if (ack) begin
         m_left--;
      end
   endtask

   task automatic tick();
      logic beat;
      int worst;
      int id;
      beat = ack && ((gnt & req) != '0);
      worst = 0;
      for (int i = 0; i < N; i++) begin
         if (rst || !req[i] || gnt[i]) wait_cnt[i] = 0;
         else if (beat) wait_cnt[i]++;
         if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      if (rnd_on) chk("starve", int'(worst <= BOUND), 1);
      @(posedge clk);
      model_step();
      #1;
      chk("gnt", int'(gnt), (m_cur < 0) ? 0 : (1 << m_cur));
      chk("gnt_id", int'(gnt_id), (m_cur < 0) ? 0 : m_cur);
      chk("gnt_valid", int'(gnt_valid), int'(m_cur >= 0));
      if (rnd_on) begin
         id = 0;
         for (int i = 0; i < N; i++) if (gnt[i]) id = i;
         chk("onehot0", int'($onehot0(gnt)), 1);
         chk("id_match", int'(gnt_id), id);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      do_reset();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_id", int'(gnt_id), 0);
      chk("rst_valid", int'(gnt_valid), 0);
      chk("rst_ptr", int'(dut.ptr), N - 1);

      weight = '0;
      req = 4'b1111;
      ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_seq", int'(gnt), seq1[k]);
      end

      do_reset();
      weight = 8'h08;
      req = 4'b0011;
      ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("weight_seq", int'(gnt), seq2[k]);
      end

      do_reset();
      weight = 8'h10;
      req = 4'b0100;
      for (int c = 0; c < 9; c++) begin
         ack = (c % 3 == 2);
         tick();
         chk("sole_gnt", int'(gnt), 4);
         chk("sole_id", int'(gnt_id), 2);
      end

      do_reset();
      weight = 8'hC0;
      req = 4'b1000;
      ack = 1'b0;
      tick();
      chk("abort_first", int'(gnt), 8);
      ack = 1'b1;
      tick();
      chk("abort_hold", int'(gnt), 8);
      ack = 1'b0;
      req = 4'b0001;
      tick();
      chk("abort_switch", int'(gnt), 1);
      chk("abort_ptr", int'(dut.ptr), 3);

      do_reset();
      weight = 8'hFF;
      req = 4'b1111;
      ack = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_gnt", int'(gnt), 0);
      chk("midrst_valid", int'(gnt_valid), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_gnt", int'(gnt), 1);

      do_reset();
      rnd_on = 1;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         ack = ($urandom_range(0, 3) != 0);
         weight = 8'($urandom);
         tick();
      end
      rnd_on = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted, handshake-aware round-robin arbiter; successor to the single-cycle round-robin grant block. It arbitrates N requesters for a shared multi-beat resource. A winner holds the grant for up to `weight+1` acknowledged beats before priority rotates. The winner is also exposed as a binary index for downstream mux select.

## Interface
- `N`, 32: number of requesters, ≥2.
- `WW`, 4: weight width per requester in bits; max burst is `2^WW` beats.
- `IW`, `$clog2(N)`: width of `gnt_id` (derived, not overridable).

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: request per requester; must stay high until its last beat is acked.
- `weight`, input, N*WW: per-requester weight; slice i is `weight[i*WW +: WW]`; sampled only at grant time.
- `ack`, input, 1: the resource accepted one beat from the current grantee this cycle.
- `gnt`, output, N: registered one-hot grant, or all-zero.
- `gnt_id`, output, IW: binary index of the granted requester; 0 when idle.
- `gnt_valid`, output, 1: equals `|gnt`.

## Operation
- Internal state:
  - `ptr` (IW): last released requester.
  - `cur` (IW): current grantee.
  - `credit` (WW): beats remaining after the current one.
  - `state`: IDLE or GRANT.
- Pick function: scan from `ptr+1` upward, wrapping modulo N, and take the first set bit of the candidate vector. Implement as a masked find-first-set with a fallback to the unmasked vector when the masked vector is empty.
- IDLE:
  - `|req`=0: stay in IDLE; `gnt`=0.
  - Otherwise: `cur`←pick(req); `gnt`←onehot(cur); `credit`←weight[cur]; go to GRANT.
- GRANT, `ack`=1 while `req[cur]`=1 and `credit`≠0:
  - `credit`←`credit`−1; grant unchanged.
- GRANT, release. Release happens on either:
  - `ack`=1 and `credit`=0 (burst exhausted), or
  - `req[cur]`=0, with or without `ack` (requester abort).
- On release:
  - `ptr`←`cur`.
  - Re-pick from the new pointer over `req` with bit `cur` cleared.
  - If that vector is empty and `req[cur]`=1, regrant `cur` with a fresh credit.
  - If nothing is requesting, go to IDLE and set `gnt`=0.
- GRANT, `ack`=0 and `req[cur]`=1: hold everything.
- Weight 0 means exactly one beat per grant. Weight changes mid-burst have no effect until the next grant.
- `ack` while in IDLE is ignored.
- Starvation bound: any requester holding `req` is granted within `(N−1)·2^WW` acked beats.

## Timing
- Reset values:
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0.
  - `state`=IDLE, `credit`=0.
  - `ptr`=N−1, so the first arbitration favours index 0.
- Reset has priority over every other input in the same cycle.
- Reset mid-burst drops the grant on the next edge with no completion beat.
- Request-to-grant latency: `req` sampled high at edge k gives `gnt` at edge k (registered output, visible after k). There is no combinational path from `req` or `ack` to `gnt`.
- Back-to-back handover: the release edge loads the next winner directly, with no idle bubble between grantees.
- Abort: if `req[cur]` drops, `gnt` deasserts or switches at the next edge. For one cycle `gnt` may still name a requester whose `req` is low; the consumer must not `ack` on that basis.

## Structure
- Package `arb_pkg`:
  - State enum `arb_state_t` {IDLE, GRANT}.
  - `onehot(idx)` and `ffs_from(vec, ptr)` helper functions.
  - `IW` derivation.
- Sub-module `rr_pick`:
  - Combinational masked find-first-set.
  - Parameters N and IW.
  - Inputs `vec`[N] and `ptr`[IW]; outputs `onehot`[N], `idx`[IW], `any`.
- Top level contains only the FSM, the credit counter and the output registers.

## Test plan
Bench configuration: N=4, WW=2 unless stated.
- Reset, then `req`=4'b1111, all weights 0, `ack` held high → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with one grant per cycle and no bubbles.
- `weight[1]`=2, others 0, `req`=4'b0011, `ack`=1 → grants 0001, 0010, 0010, 0010, 0001, …, so requester 1 gets exactly 3 consecutive beats.
- `req`=4'b0100 only, weight 1, `ack` pulsed every 3rd cycle → `gnt`=0100 held continuously. After 2 acks, requester 2 is regranted with fresh credit because it is the sole requester; `gnt_id` stays 2.
- Abort: requester 3 granted with weight 3; drop `req[3]` after 1 ack while `req[0]`=1 → next edge `gnt`=0001 and `ptr`=3.
- Assert `rst` mid-burst with `req`=1111 → next edge `gnt`=0, `gnt_valid`=0. After `rst` falls, the first grant is 0001.
- Random `req`/`ack`/`weight` for 10k cycles:
  - assert `gnt` is one-hot or zero;
  - assert `gnt_id` matches `gnt`;
  - assert the starvation bound of 12 acked beats holds for every waiting requester.
